// File: rtl/bypass_scoreboard.sv
// Operand bypass network with a pending-register scoreboard for long-latency ops.
// Forwards from the youngest matching producer stage and raises load-use/RAW/WAW stalls.
module bypass_scoreboard #(
  parameter int XLEN       = 32,
  parameter int TAG_W      = 5,
  parameter int NUM_STAGES = 3,
  parameter int NUM_SRC    = 2,
  parameter int CNT_W      = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic [NUM_SRC*TAG_W-1:0]   src_tag,
  input  logic                       issue_valid,
  input  logic                       issue_write_rd,
  input  logic                       issue_long,
  input  logic [TAG_W-1:0]           issue_rd,
  input  logic [NUM_STAGES-1:0]      stg_valid,
  input  logic [NUM_STAGES-1:0]      stg_write_rd,
  input  logic [NUM_STAGES-1:0]      stg_ready,
  input  logic [NUM_STAGES*TAG_W-1:0] stg_rd,
  input  logic [NUM_STAGES*XLEN-1:0] stg_value,
  input  logic                       long_done,
  input  logic [TAG_W-1:0]           long_done_rd,
  output logic                       stall,
  output logic [NUM_SRC-1:0]         bypass,
  output logic [NUM_SRC*XLEN-1:0]    bypass_value,
  output logic [2**TAG_W-1:0]        pending,
  output logic [CNT_W-1:0]           stall_count
);

  localparam int NUM_REGS = 2**TAG_W;

  logic [NUM_SRC-1:0]  hit_not_ready;
  logic [NUM_SRC-1:0]  pend_raw;
  logic                waw;
  logic                fire;
  logic                set_en;
  logic [NUM_REGS-1:0] pending_next;

  // NOTE: every combinational output gets a default before the loops so no latch is inferred.
  always_comb begin
    logic                hit;
    logic [TAG_W-1:0]    tag;
    bypass        = '0;
    bypass_value  = '0;
    hit_not_ready = '0;
    pend_raw      = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      hit = 1'b0;
      tag = src_tag[s*TAG_W +: TAG_W];
      // Walk oldest to youngest so the youngest match overwrites and wins.
      for (int k = NUM_STAGES-1; k >= 0; k--) begin
        if (stg_valid[k] && stg_write_rd[k] && src_valid[s] && tag != '0 &&
            stg_rd[k*TAG_W +: TAG_W] == tag) begin
          hit                          = 1'b1;
          bypass_value[s*XLEN +: XLEN] = stg_value[k*XLEN +: XLEN];
          hit_not_ready[s]             = !stg_ready[k];
        end
      end
      bypass[s]   = hit;
      pend_raw[s] = !hit && src_valid[s] && tag != '0 && pending[tag];
    end
  end

  assign waw    = issue_write_rd && issue_rd != '0 && pending[issue_rd];
  assign stall  = !reset && issue_valid && ((|hit_not_ready) || (|pend_raw) || waw);
  assign fire   = issue_valid && !stall;
  assign set_en = fire && issue_long && issue_write_rd && issue_rd != '0;

  // Clear is applied first so a same-cycle set on the same tag wins.
  always_comb begin
    pending_next = pending;
    if (long_done) pending_next[long_done_rd] = 1'b0;
    if (set_en)    pending_next[issue_rd]     = 1'b1;
    pending_next[0] = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall && stall_count != '1) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_bypass_scoreboard.sv
// Directed bench for bypass_scoreboard: forwarding priority, stalls, scoreboard and counter.
// A second instance with a 4-bit counter exercises saturation in a short run.
module tb_bypass_scoreboard;

  localparam int XLEN = 32;
  localparam int TAG_W = 5;
  localparam int NS = 3;
  localparam int NSRC = 2;

  logic                 clock;
  logic                 reset;
  logic                 flush;
  logic [NSRC-1:0]      src_valid;
  logic [NSRC*TAG_W-1:0] src_tag;
  logic                 issue_valid;
  logic                 issue_write_rd;
  logic                 issue_long;
  logic [TAG_W-1:0]     issue_rd;
  logic [NS-1:0]        stg_valid;
  logic [NS-1:0]        stg_write_rd;
  logic [NS-1:0]        stg_ready;
  logic [NS*TAG_W-1:0]  stg_rd;
  logic [NS*XLEN-1:0]   stg_value;
  logic                 long_done;
  logic [TAG_W-1:0]     long_done_rd;

  logic                 stall, stall_s;
  logic [NSRC-1:0]      bypass, bypass_s;
  logic [NSRC*XLEN-1:0] bypass_value, bypass_value_s;
  logic [31:0]          pending, pending_s;
  logic [31:0]          stall_count;
  logic [3:0]           stall_count_s;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  bypass_scoreboard dut (
    .clock(clock), .reset(reset), .flush(flush),
    .src_valid(src_valid), .src_tag(src_tag),
    .issue_valid(issue_valid), .issue_write_rd(issue_write_rd),
    .issue_long(issue_long), .issue_rd(issue_rd),
    .stg_valid(stg_valid), .stg_write_rd(stg_write_rd), .stg_ready(stg_ready),
    .stg_rd(stg_rd), .stg_value(stg_value),
    .long_done(long_done), .long_done_rd(long_done_rd),
    .stall(stall), .bypass(bypass), .bypass_value(bypass_value),
    .pending(pending), .stall_count(stall_count)
  );

  bypass_scoreboard #(.CNT_W(4)) dut_sat (
    .clock(clock), .reset(reset), .flush(flush),
    .src_valid(src_valid), .src_tag(src_tag),
    .issue_valid(issue_valid), .issue_write_rd(issue_write_rd),
    .issue_long(issue_long), .issue_rd(issue_rd),
    .stg_valid(stg_valid), .stg_write_rd(stg_write_rd), .stg_ready(stg_ready),
    .stg_rd(stg_rd), .stg_value(stg_value),
    .long_done(long_done), .long_done_rd(long_done_rd),
    .stall(stall_s), .bypass(bypass_s), .bypass_value(bypass_value_s),
    .pending(pending_s), .stall_count(stall_count_s)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_cnt(input string tag);
    check({tag, "_cnt"}, 64'(stall_count), 64'(exp_cnt));
    check({tag, "_cnt_sat"}, 64'(stall_count_s), 64'((exp_cnt > 15) ? 15 : exp_cnt));
  endtask

  // One rising edge; the caller states whether stall is high during that cycle.
  task automatic tick(input bit stalled);
    @(posedge clock);
    if (stalled) exp_cnt++;
    #1;
  endtask

  task automatic clear_inputs();
    flush = 0; src_valid = '0; src_tag = '0;
    issue_valid = 0; issue_write_rd = 0; issue_long = 0; issue_rd = '0;
    stg_valid = '0; stg_write_rd = '0; stg_ready = '0; stg_rd = '0; stg_value = '0;
    long_done = 0; long_done_rd = '0;
  endtask

  task automatic stage(input int k, input bit v, input bit w, input bit r,
                       input logic [TAG_W-1:0] rd, input logic [XLEN-1:0] val);
    stg_valid[k] = v; stg_write_rd[k] = w; stg_ready[k] = r;
    stg_rd[k*TAG_W +: TAG_W] = rd;
    stg_value[k*XLEN +: XLEN] = val;
  endtask

  task automatic src(input int s, input bit v, input logic [TAG_W-1:0] tag);
    src_valid[s] = v;
    src_tag[s*TAG_W +: TAG_W] = tag;
  endtask

  task automatic issue(input bit lng, input logic [TAG_W-1:0] rd);
    issue_valid = 1; issue_write_rd = 1; issue_long = lng; issue_rd = rd;
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    tick(0);

    // Reset: stall masked, bypass still live, state cleared at the edge.
    stage(0, 1, 1, 0, 5'd3, 32'h33); src(1, 1, 5'd3); issue_valid = 1; #1;
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_bypass", 64'(bypass), 64'b10);
    tick(0);
    check("rst_pending", 64'(pending), 64'd0);
    check_cnt("rst");

    // Load-use: not-ready producer stalls and counts each cycle.
    reset = 0; #1;
    check("lu_stall", 64'(stall), 64'd1);
    tick(1); tick(1); tick(1);
    check_cnt("lu");
    stg_ready[0] = 1; #1;
    check("lu_release", 64'(stall), 64'd0);
    check("lu_value", 64'(bypass_value[63:32]), 64'h33);
    tick(0);
    check_cnt("lu_hold");

    // Priority: youngest stage wins, unmatched operand reads zero.
    clear_inputs();
    stage(0, 1, 1, 1, 5'd7, 32'hA); stage(1, 1, 1, 1, 5'd7, 32'hB); stage(2, 1, 1, 1, 5'd7, 32'hC);
    src(0, 1, 5'd7); src(1, 1, 5'd8); issue_valid = 1; #1;
    check("prio_bypass", 64'(bypass), 64'b01);
    check("prio_val0", 64'(bypass_value[31:0]), 64'hA);
    check("prio_val1", 64'(bypass_value[63:32]), 64'h0);
    check("prio_stall", 64'(stall), 64'd0);
    stg_valid[0] = 0; #1;
    check("prio_s1", 64'(bypass_value[31:0]), 64'hB);
    stg_write_rd[1] = 0; #1;
    check("prio_s2", 64'(bypass_value[31:0]), 64'hC);
    stg_write_rd[2] = 0; #1;
    check("prio_none", 64'(bypass), 64'b00);
    check("prio_none_val", 64'(bypass_value[31:0]), 64'h0);

    // x0: never forwarded, never stalls, never pending.
    clear_inputs();
    for (int k = 0; k < NS; k++) stage(k, 1, 1, 0, 5'd0, 32'(k + 1));
    src(0, 1, 5'd0); src(1, 1, 5'd0); issue(1, 5'd0); #1;
    check("x0_bypass", 64'(bypass), 64'b00);
    check("x0_stall", 64'(stall), 64'd0);
    tick(0);
    check("x0_pending", 64'(pending), 64'd0);

    // Long RAW on rd=9.
    clear_inputs();
    issue(1, 5'd9); #1;
    check("long_fire", 64'(stall), 64'd0);
    tick(0);
    check("long_pending", 64'(pending), 64'h200);
    issue_long = 0; issue_write_rd = 0; src(0, 1, 5'd9); #1;
    check("raw_stall", 64'(stall), 64'd1);
    stage(1, 1, 1, 1, 5'd9, 32'h99); #1;
    check("raw_fwd_nostall", 64'(stall), 64'd0);
    check("raw_fwd_val", 64'(bypass_value[31:0]), 64'h99);
    stg_valid = '0; long_done = 1; long_done_rd = 5'd9; #1;
    check("raw_done_stall", 64'(stall), 64'd1);
    tick(1);
    long_done = 0; #1;
    check("raw_pending_clr", 64'(pending), 64'd0);
    check("raw_release", 64'(stall), 64'd0);

    // WAW on rd=4, then same-cycle clear and set: set wins.
    clear_inputs();
    issue(1, 5'd4); #1;
    tick(0);
    check("waw_pending", 64'(pending), 64'h10);
    check("waw_stall", 64'(stall), 64'd1);
    long_done = 1; long_done_rd = 5'd4; #1;
    check("waw_done_stall", 64'(stall), 64'd1);
    tick(1);
    check("waw_cleared", 64'(pending), 64'd0);
    check("coll_fire", 64'(stall), 64'd0);
    tick(0);
    check("set_wins", 64'(pending), 64'h10);
    clear_inputs();
    long_done = 1; long_done_rd = 5'd4; #1;
    tick(0);
    check("done_clr", 64'(pending), 64'd0);

    // Flush overrides a same-cycle set.
    clear_inputs();
    issue(1, 5'd5); #1;
    tick(0);
    check("flush_pre", 64'(pending), 64'h20);
    issue_rd = 5'd6; flush = 1; #1;
    check("flush_fire", 64'(stall), 64'd0);
    tick(0);
    check("flush_clr", 64'(pending), 64'd0);
    check_cnt("flush");

    // Park a long op on rd=10, then saturate the counters with a held stall.
    clear_inputs();
    issue(1, 5'd10); #1;
    tick(0);
    check("mid_pending", 64'(pending), 64'h400);
    clear_inputs();
    stage(0, 1, 1, 0, 5'd3, 32'h33); src(1, 1, 5'd3); issue_valid = 1; #1;
    for (int i = 0; i < 20; i++) tick(1);
    check_cnt("sat");
    check("sat_stall", 64'(stall_s), 64'd1);

    // Reset mid-long-op drops pending and the counters; a late writeback is harmless.
    reset = 1; #1;
    check("rst2_stall", 64'(stall), 64'd0);
    tick(0);
    exp_cnt = 0;
    check("rst2_pending", 64'(pending), 64'd0);
    check_cnt("rst2");
    reset = 0; clear_inputs();
    long_done = 1; long_done_rd = 5'd10; #1;
    tick(0);
    check("late_done", 64'(pending), 64'd0);
    check_cnt("late_done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
